// File: rtl/multiprecision_add_ctrl.sv
// ---------------------------------------------------------------------------
// multiprecision_add_ctrl
//
// Byte-serial multi-precision adder controller wrapped around an external
// combinational 8-bit full adder. Operand byte pairs arrive least-significant
// byte first, one per accepted beat. The adder carry-out of each byte is
// chained into the next byte's carry-in. Every sum byte is captured in a
// single-entry output stage with valid/ready handshaking. The most-significant
// byte of an operation also carries the final carry and the signed overflow.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input byte-pair handshake
//   in_a, in_b            operand bytes
//   in_cin                operation carry-in, used only on byte 0
//   flush                 synchronous abort of the partially accepted operation
//   add_a, add_b, add_cin drive the external adder (combinational)
//   add_sum, add_cout     external adder result (same cycle)
//   out_valid / out_ready result byte handshake
//   out_sum, out_last     result byte and most-significant-byte marker
//   out_cout, out_ovf     final carry / signed overflow, valid with out_last
//   busy                  an operation is partially accepted
// ---------------------------------------------------------------------------
module multiprecision_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_cin,
    input  logic       flush,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_last,
    output logic       out_cout,
    output logic       out_ovf,
    output logic       busy
);

    localparam int               CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic               accept;
    logic               is_last;

    logic               vld_p1;
    logic signed [7:0]  sum_p1;
    logic               last_p1;
    logic               cout_p1;
    logic               ovf_p1;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic signed [7:0] a,
                                        input logic signed [7:0] b,
                                        input logic signed [7:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    // Single output slot: a new byte may enter when the slot is empty or
    // is being drained on this same edge.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign is_last  = (cnt == LAST_CNT);
    assign busy     = (cnt != '0);

    // Adder path is purely combinational; byte 0 takes the operation carry-in.
    assign add_a    = in_a;
    assign add_b    = in_b;
    assign add_cin  = (cnt == '0) ? in_cin : carry_q;

    // Stage 0 -> 1: byte position and carry chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= add_cout;
            cnt     <= is_last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Stage 1: output register; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            last_p1 <= 1'b0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            sum_p1  <= add_sum;
            last_p1 <= is_last;
            cout_p1 <= is_last && add_cout;
            ovf_p1  <= is_last && signed_ovf(in_a, in_b, add_sum);
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_last  = last_p1;
    assign out_cout  = cout_p1;
    assign out_ovf   = ovf_p1;

endmodule

// File: doc/multiprecision_add_ctrl.md
# multiprecision_add_ctrl

Byte-serial multi-precision adder controller that sits directly around the 8-bit full adder. It drives the adder with one operand byte pair per cycle, least-significant byte first, and chains the adder's carry-out into the next byte's carry-in. It registers each sum byte into a one-entry output stage with valid/ready handshakes on both sides. On the last byte it reports the final carry and the signed overflow.

## Interface
- NBYTES, 4, operand length in bytes (legal 1..16); one operation = NBYTES accepted input beats
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input byte pair valid
- in_ready  out  1  controller can accept a byte pair this cycle
- in_a  in  8  operand A byte
- in_b  in  8  operand B byte
- in_cin  in  1  carry-in of the operation; sampled only on byte 0
- flush  in  1  synchronous abort of the current operation
- add_a  out  8  to adder A; combinationally equal to in_a
- add_b  out  8  to adder B; combinationally equal to in_b
- add_cin  out  1  to adder Cin; in_cin when cnt==0, else carry_q
- add_sum  in  8  from adder Sum (combinational, same cycle)
- add_cout  in  1  from adder Cout
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts result byte
- out_sum  out  8  result byte
- out_last  out  1  out_sum is the most-significant byte of the operation
- out_cout  out  1  final carry-out; meaningful only with out_last, 0 otherwise
- out_ovf  out  1  signed overflow of the full operation; meaningful only with out_last, 0 otherwise
- busy  out  1  high while cnt != 0 (operation partially accepted)

## Operation
- Internal state: byte counter cnt (0..NBYTES-1), carry register carry_q, and output register {out_valid, out_sum, out_last, out_cout, out_ovf}.
- States are implied by cnt:
  - IDLE (cnt==0): next accepted byte starts an operation and uses in_cin.
  - RUN (cnt!=0): next accepted byte uses carry_q.
- in_ready = !out_valid || out_ready (single output slot, pass-through when drained).
- Accept = in_valid && in_ready && !flush. On accept:
  - out_sum <= add_sum.
  - out_last <= (cnt==NBYTES-1).
  - carry_q <= add_cout.
  - out_cout <= last ? add_cout : 0.
  - out_ovf <= last ? (in_a[7]==in_b[7] && add_sum[7]!=in_a[7]) : 0.
  - cnt <= last ? 0 : cnt+1 (wraps after last byte; back-to-back operations need no gap).
- out_valid: set on accept; cleared on out_ready without accept; held while out_ready low. Output fields are stable while out_valid && !out_ready.
- flush: cnt <= 0, carry_q <= 0; any input beat in the same cycle is dropped (flush wins). The output register is untouched, so a pending byte still drains. busy falls the next cycle.
- NBYTES==1: every byte is last; the block behaves as a registered 8-bit adder with handshake.
- in_cin is ignored when cnt!=0.

## Timing
- Reset (rst_n low, async): cnt=0, carry_q=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, busy=0. in_ready=1 as soon as reset is released.
- Reset mid-operation discards the partial operation and the pending output byte.
- Latency: accept at edge k gives out_valid=1 after edge k, visible in cycle k+1.
- Throughput: 1 byte/cycle while out_ready=1; NBYTES cycles per operation.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 combinationally. No byte is lost or duplicated.
- Simultaneous out_ready and accept: the old byte leaves and the new byte loads on the same edge; out_valid stays 1.
- add_* outputs are purely combinational from inputs and carry_q/cnt; there is no register on the adder path.

## Test plan
- NBYTES=1, A=0xDB, B=0xAA, cin=1 -> out_sum=0x86, out_cout=1, out_ovf=0, out_last=1, one cycle after accept.
- NBYTES=1, A=0x63, B=0x95, cin=0 -> out_sum=0xF8, out_cout=0, out_ovf=0.
- NBYTES=2, 0x12FF+0x0001, cin=0 -> bytes 0x00 (last=0), then 0x13 (last=1, cout=0, ovf=0). 0x7FFF+0x0001 -> 0x00, then 0x80 with ovf=1, cout=0.
- NBYTES=2, back-to-back operations with out_ready held 0 for 3 cycles after the first byte -> in_ready=0 for those cycles, out_sum stable, all 4 bytes delivered in order after release.
- NBYTES=4: send 2 bytes of 0xFF+0x01 (carry_q=1), pulse flush together with a valid beat, then 4 bytes of 0x01+0x01, cin=0 -> beat dropped, outputs 0x02 x4 with last on the 4th, cout=0 (no stale carry).
- Assert rst_n low after byte 1 of 4 while out_valid=1 -> all outputs reach reset values immediately; the next operation starts at byte 0 using in_cin.
